mcycle_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the ARM core datapath. It accepts a MUL/DIV request from the Execute stage and runs an iterative shift-add (multiply) or restoring shift-subtract (divide) loop, one step per clock. It drives Busy so the pipeline stalls until the result is ready. It runs on the core clock CLK; no separate fast clock is used.

---
 rtl/mcycle_pkg.sv | 18 +
 rtl/mcycle_step.sv | 43 ++++
 rtl/mcycle_seq.sv | 116 +++++++++++
 tb/tb_mcycle_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared types for the multi-cycle multiply/divide sequencer.
//   state_e  - sequencer FSM states
//   OP_*     - MCycleOp encodings (bit1: 0=MUL 1=DIV, bit0: 0=unsigned 1=signed)
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SIGN    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

endpackage

// File: rtl/mcycle_step.sv
// mcycle_step: one combinational iteration of the shift-add multiply or
// restoring shift-subtract divide.
//   acc      in   2*WIDTH  MUL: {hi, lo/multiplier}; DIV: {remainder, dividend/quotient}
//   operand  in   WIDTH    multiplicand (MUL) or divisor (DIV) magnitude
//   is_div   in   1        select divide iteration
//   acc_nxt  out  2*WIDTH  accumulator after this iteration (DIV: bit 0 left clear)
//   q_bit    out  1        quotient bit produced by this DIV iteration
module mcycle_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0] sum;     // MUL: hi + multiplicand with carry
  logic [WIDTH:0] rem_sh;  // DIV: WIDTH+1-bit partial remainder after shift-in

  always_comb begin
    acc_nxt = '0;
    q_bit   = 1'b0;
    sum     = '0;
    rem_sh  = '0;
    if (is_div) begin
      // Shift the next dividend bit into the remainder; subtract when it fits.
      // The remainder is always < divisor afterwards, so WIDTH bits hold it.
      // The quotient slot (bit 0) is filled by the sequencer from q_bit.
      rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      q_bit   = (rem_sh >= {1'b0, operand});
      acc_nxt = {(q_bit ? WIDTH'(rem_sh - {1'b0, operand}) : rem_sh[WIDTH-1:0]),
                 acc[WIDTH-2:0], 1'b0};
    end else begin
      // Conditional add into the high half, then shift the whole thing right;
      // the carry drops into the top bit so nothing is lost.
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// mcycle_seq: multi-cycle MUL/DIV sequencer for the Execute stage.
// Operands are latched as magnitudes on the IDLE->COMPUTE edge, WIDTH
// iterations run one per clock, signs are fixed up in SIGN, and Done pulses
// for one cycle in DONE. Busy stalls the pipeline from the Start cycle until
// the cycle before Done.
//   CLK       in   1      core clock, rising edge
//   Reset     in   1      async active-low reset
//   Start     in   1      request, held while the instruction sits in Execute
//   MCycleOp  in   2      bit1 DIV/MUL, bit0 signed/unsigned
//   Operand1  in   WIDTH  multiplicand / dividend
//   Operand2  in   WIDTH  multiplier / divisor
//   Result1   out  WIDTH  product low / quotient
//   Result2   out  WIDTH  product high / remainder
//   Busy      out  1      stall request
//   Done      out  1      one-cycle result-valid pulse
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               q_bit;

  // Magnitudes of the incoming operands. abs(MIN) wraps to 2^(WIDTH-1),
  // which is the right unsigned magnitude.
  logic             s1_in, s2_in;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    s1_in = MCycleOp[0] & Operand1[WIDTH-1];
    s2_in = MCycleOp[0] & Operand2[WIDTH-1];
    mag1  = s1_in ? -Operand1 : Operand1;
    mag2  = s2_in ? -Operand2 : Operand2;
  end

  mcycle_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (opnd),
    .is_div  (is_div),
    .acc_nxt (acc_nxt),
    .q_bit   (q_bit)
  );

  // No stall request while held in reset, even if Start is high.
  assign Busy = Reset & ((state == IDLE & Start) | state == COMPUTE | state == SIGN);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          is_div <= MCycleOp[1];
          sign1  <= s1_in;
          sign2  <= s2_in;
          // MUL: multiplier in the low half, multiplicand added in.
          // DIV: dividend in the low half shifts into the remainder.
          opnd   <= MCycleOp[1] ? mag2 : mag1;
          acc    <= {{WIDTH{1'b0}}, (MCycleOp[1] ? mag1 : mag2)};
          cnt    <= '0;
          state  <= COMPUTE;
        end
        COMPUTE: begin
          acc <= is_div ? {acc_nxt[2*WIDTH-1:1], q_bit} : acc_nxt;
          if (cnt == CNT_W'(WIDTH-1)) state <= SIGN;
          else                        cnt   <= cnt + CNT_W'(1);
        end
        SIGN: begin
          if (is_div) begin
            // Divide-by-zero leaves quotient all ones and remainder = |dividend|;
            // skipping quotient negation and re-applying the dividend sign
            // to the remainder yields the raw dividend.
            Result1 <= ((sign1 ^ sign2) && opnd != '0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            Result2 <= sign1 ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {Result2, Result1} <= (sign1 ^ sign2) ? -acc : acc;
          end
          Done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;   // Start ignored here so a held Start can't retrigger
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_seq.sv
// tb_mcycle_seq: self-checking bench for mcycle_seq (WIDTH=32) against an
// arithmetic reference model.
module tb_mcycle_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;   // cycles from Start to Done

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy, Done;

  int n_tests = 0;
  int n_fail  = 0;

  mcycle_seq #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  // Reference: returns {Result2, Result1}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = {32'h0, a} * {32'h0, b};
      2'b01: p = 64'(sa * sb);
      default: begin
        if (b == 32'h0)      p = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) p = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Drive one request with Start high for a single cycle, scramble inputs
  // afterwards, and report what came back and when.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r2,
                        output int done_at, output int busy_cnt);
    done_at  = -1;
    busy_cnt = 0;
    r1 = '0;
    r2 = '0;
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    for (int t = 0; t < 100 && done_at < 0; t++) begin
      @(negedge CLK);
      if (Done) begin
        done_at = t; r1 = Result1; r2 = Result2;
        if (Busy) busy_cnt = busy_cnt + 1000;   // Busy must be low with Done
      end else if (Busy) busy_cnt++;
      @(posedge CLK); #1;
      Start = 1'b0;
      MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; MCycleOp = '0; Operand1 = '0; Operand2 = '0;
    #2 Reset = 1'b0;
    #2;
    n_tests++; if (Busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_tests++; if (Result1 !== '0)   begin n_fail++; $display("FAIL reset_r1 got %h want 0", Result1); end
    n_tests++; if (Result2 !== '0)   begin n_fail++; $display("FAIL reset_r2 got %h want 0", Result2); end
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a, b, r1, r2;
  } vec_t;

  task automatic test_directed;
    vec_t v[10];
    logic [31:0] r1, r2;
    int d, bc;
    v = '{
      '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE},
      '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF},
      '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000},
      '{2'b10, 32'd100,       32'd7,         32'd14,        32'd2},
      '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF},
      '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000},
      '{2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5},
      '{2'b11, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5},
      '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9},
      '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1}
    };
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r1, r2, d, bc);
      n_tests++; if (r1 !== v[i].r1) begin n_fail++; $display("FAIL dir%0d_r1 got %h want %h", i, r1, v[i].r1); end
      n_tests++; if (r2 !== v[i].r2) begin n_fail++; $display("FAIL dir%0d_r2 got %h want %h", i, r2, v[i].r2); end
      n_tests++; if (d  !== LAT)     begin n_fail++; $display("FAIL dir%0d_done_lat got %0d want %0d", i, d, LAT); end
      n_tests++; if (bc !== LAT)     begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, LAT); end
    end
  endtask

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, r1, r2;
    logic [63:0] exp;
    int d, bc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      exp = model(op, a, b);
      run_op(op, a, b, r1, r2, d, bc);
      n_tests++; if ({r2, r1} !== exp) begin n_fail++; $display("FAIL rnd%0d op%0d %h,%h got %h_%h want %h", i, op, a, b, r2, r1, exp); end
      n_tests++; if (d !== LAT) begin n_fail++; $display("FAIL rnd%0d_done_lat got %0d want %0d", i, d, LAT); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r1, r2;
    logic [63:0] exp;
    int d, bc;
    // Leave a known nonzero result in the output registers first.
    run_op(2'b00, 32'd3, 32'd5, r1, r2, d, bc);
    n_tests++; if (r1 !== 32'd15) begin n_fail++; $display("FAIL rmid_pre_r1 got %h want f", r1); end
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'h1234_5678; Operand2 = 32'h9ABC_DEF0;
    repeat (10) begin @(posedge CLK); #1; Start = 1'b0; end
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", Busy); end
    Reset = 1'b0;
    #1;
    n_tests++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0)  begin n_fail++; $display("FAIL rmid_done got %b want 0", Done); end
    n_tests++; if (Result1 !== '0) begin n_fail++; $display("FAIL rmid_r1 got %h want 0", Result1); end
    n_tests++; if (Result2 !== '0) begin n_fail++; $display("FAIL rmid_r2 got %h want 0", Result2); end
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1;
    exp = model(2'b01, 32'hFFFF_FF00, 32'h0001_0003);
    run_op(2'b01, 32'hFFFF_FF00, 32'h0001_0003, r1, r2, d, bc);
    n_tests++; if ({r2, r1} !== exp) begin n_fail++; $display("FAIL rmid_after got %h_%h want %h", r2, r1, exp); end
    n_tests++; if (d !== LAT)  begin n_fail++; $display("FAIL rmid_after_lat got %0d want %0d", d, LAT); end
    n_tests++; if (bc !== LAT) begin n_fail++; $display("FAIL rmid_after_busy got %0d want %0d", bc, LAT); end
  endtask

  // Start held through DONE and into the following IDLE cycle: exactly one
  // extra operation starts there, using the operands present in that cycle.
  task automatic test_back_to_back;
    logic [63:0] exp1, exp2, got1, got2;
    int n_done, t1, t2;
    logic busy_re;
    n_done = 0; t1 = -1; t2 = -1; got1 = '0; got2 = '0; busy_re = 1'b0;
    exp1 = model(2'b11, 32'hFFFF_FF9C, 32'd7);
    exp2 = model(2'b00, 32'hDEAD_BEEF, 32'h0000_1234);
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'hFFFF_FF9C; Operand2 = 32'd7;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (t == LAT + 1) busy_re = Busy;
      if (Done) begin
        n_done++;
        if (n_done == 1) begin t1 = t; got1 = {Result2, Result1}; end
        if (n_done == 2) begin t2 = t; got2 = {Result2, Result1}; end
      end
      @(posedge CLK); #1;
      if (t == 0) begin MCycleOp = 2'b00; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h0000_1234; end
      if (t == LAT + 1) begin Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; end
    end
    n_tests++; if (n_done !== 2)          begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    n_tests++; if (t1 !== LAT)            begin n_fail++; $display("FAIL b2b_first_lat got %0d want %0d", t1, LAT); end
    n_tests++; if (t2 !== 2*LAT + 1)      begin n_fail++; $display("FAIL b2b_second_lat got %0d want %0d", t2, 2*LAT+1); end
    n_tests++; if (busy_re !== 1'b1)      begin n_fail++; $display("FAIL b2b_restart_busy got %b want 1", busy_re); end
    n_tests++; if (got1 !== exp1)         begin n_fail++; $display("FAIL b2b_first_res got %h want %h", got1, exp1); end
    n_tests++; if (got2 !== exp2)         begin n_fail++; $display("FAIL b2b_second_res got %h want %h", got2, exp2); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
